multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multi-cycle successor to the single-cycle processor controller. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding in one cycle, so the datapath can share one ALU and tolerate wait-stated instruction and data memories via ready handshakes. It sits between the instruction register, the register file, the ALU and the memory interfaces. It also traps illegal opcodes and counts retired instructions.

## Interface
- OP_W, 5, opcode width; the opcode map uses the low 5 bits, and upper bits must be 0 for a legal opcode
- ALUOP_W, 4, ALU operation code width (minimum 4)
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inst_op  in  OP_W  opcode from instruction register, valid from DECODE onward
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- PCWr  out  1  PC write enable
- PCSrc  out  1  0 = PC+4, 1 = branch target
- IRWr  out  1  instruction register write enable
- RegSrc  out  1  register-file second read address select: 1 = rt, 0 = rd
- RegEn  out  1  register-file write enable
- ALUSrc  out  1  0 = register, 1 = immediate
- ALUOp  out  ALUOP_W  ALU operation
- DmemRd  out  1  data memory read request
- DmemWr  out  1  data memory write request
- WrSrc  out  1  write-back source: 1 = ALU, 0 = memory
- illegal  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  retired-instruction count

## Operation
- Opcode map:
  - add 00010, sub 00011, and 00100, or 00101, xor 00110
  - sr 01000, sra 01001, sl 01010
  - addi 10010, andi 10100, ori 10101, xori 10110
  - lw 11100, sw 11101, beq 11110, bne 11111
- ALUOp encoding: add 0000, sub 0001, and 0100, or 0101, xor 0111, sr 1000, sl 1001, sra 1010; upper bits 0 when ALUOP_W > 4.
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP.
- FETCH:
  - waits for imem_ready.
  - In the imem_ready cycle, IRWr=1, PCWr=1, PCSrc=0, then go to DECODE.
- DECODE: latch inst_op into an internal register. Next state:
  - R-type or I-type ALU op -> EXEC
  - lw/sw -> EXEC
  - beq/bne -> BRANCH
  - any other value -> TRAP
- EXEC: ALUOp/ALUSrc driven per latched op.
  - R-type: ALUSrc=0, RegSrc=1; -> WB.
  - I-type: ALUSrc=1; -> WB.
  - lw/sw: ALUOp=add, ALUSrc=1; -> MEM.
- MEM:
  - lw: DmemRd=1; sw: DmemWr=1, RegSrc=0.
  - Held until dmem_ready.
  - On dmem_ready: lw -> WB; sw retires -> FETCH.
- WB: RegEn=1 for exactly one cycle; WrSrc=0 for lw, else 1. Retires -> FETCH.
- BRANCH:
  - ALUOp=sub, ALUSrc=0, RegSrc=0.
  - PCWr=PCSrc=(zero for beq, !zero for bne), evaluated combinationally on zero this cycle.
  - Retires -> FETCH.
- TRAP: illegal=1, all enables 0, terminal until reset.
- retired increments by 1 on each retiring transition and wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0. No x values are driven in any state.
- Controls are a decode of state + latched op (Moore), except BRANCH PCWr/PCSrc and the FETCH handshake-qualified IRWr/PCWr.

## Timing
- rst_n low (async):
  - state=FETCH, latched op=0, illegal=0, retired=0.
  - All outputs 0 while reset is held.
- Reset mid-instruction aborts it with no retire and no pending writes.
- Latency with zero wait states:
  - ALU ops: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
- Each wait cycle adds one.
- imem_ready/dmem_ready are sampled only in FETCH/MEM respectively and ignored elsewhere.
- DmemRd/DmemWr stay stable and asserted while waiting.
- RegEn, IRWr, DmemWr never assert in the same cycle.
- retired updates on the clock edge leaving WB/BRANCH/MEM(sw).

## Test plan
- Reset: hold rst_n=0 mid-EXEC -> all outputs 0, retired=0; release -> FETCH; IRWr=1 the first cycle imem_ready=1.
- add with imem_ready=1:
  - IRWr/PCWr in cycle 1.
  - EXEC has ALUOp=0000, RegSrc=1.
  - WB has RegEn=1, WrSrc=1.
  - retired=1 after 4 cycles.
- lw with dmem_ready low 3 cycles:
  - DmemRd=1 for 4 cycles.
  - WB has WrSrc=0, RegEn=1.
  - Total 8 cycles.
- beq, zero=1 -> PCWr=PCSrc=1 in BRANCH; bne, zero=1 -> PCWr=0; each 3 cycles.
- Opcode 00000:
  - DECODE -> TRAP, illegal=1.
  - No RegEn/DmemWr ever asserted.
  - retired unchanged until reset.
- CNT_W=4: retire 17 instructions -> retired=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle processor controller: sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH, traps illegal opcodes, counts retired instructions.
// Latency: ALU op 4 cycles, lw 5, sw 4, beq/bne 3 with zero wait states; each imem/dmem wait cycle adds one.
// Backpressure: FETCH holds until imem_ready, MEM holds (request stable) until dmem_ready; TRAP is terminal until reset.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   inst_op                 opcode from the instruction register, valid from DECODE onward
//   zero                    ALU zero flag, used combinationally in BRANCH
//   imem_ready, dmem_ready  memory handshakes, sampled only in FETCH / MEM
//   PCWr..WrSrc, ALUOp      datapath controls (all 0 while reset is held)
//   illegal                 sticky illegal-opcode flag
//   retired                 retired-instruction count, wraps modulo 2^CNT_W
module multicycle_controller #(
    parameter int OP_W    = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    inst_op,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               PCWr,
    output logic               PCSrc,
    output logic               IRWr,
    output logic               RegSrc,
    output logic               RegEn,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               DmemRd,
    output logic               DmemWr,
    output logic               WrSrc,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_RTYPE, C_ITYPE, C_LW, C_SW, C_BR
    } cls_t;

    // Opcode class; any nonzero bit above the 5-bit map makes the opcode illegal.
    function automatic cls_t classify(input logic [OP_W-1:0] op);
        cls_t c;
        c = C_ILL;
        if ((op >> 5) == '0) begin
            case (op[4:0])
                5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                5'b01000, 5'b01001, 5'b01010:          c = C_RTYPE;
                5'b10010, 5'b10100, 5'b10101, 5'b10110: c = C_ITYPE;
                5'b11100:                              c = C_LW;
                5'b11101:                              c = C_SW;
                5'b11110, 5'b11111:                    c = C_BR;
                default:                               c = C_ILL;
            endcase
        end
        return c;
    endfunction

    // R-type and I-type share ALU codes (addi->add etc.); shifts do not follow
    // the opcode's low bits, so the full 5-bit value is decoded.
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        logic [3:0] a;
        case (op)
            5'b00010, 5'b10010: a = 4'b0000;
            5'b00011:           a = 4'b0001;
            5'b00100, 5'b10100: a = 4'b0100;
            5'b00101, 5'b10101: a = 4'b0101;
            5'b00110, 5'b10110: a = 4'b0111;
            5'b01000:           a = 4'b1000;
            5'b01010:           a = 4'b1001;
            5'b01001:           a = 4'b1010;
            default:            a = 4'b0000;
        endcase
        return a;
    endfunction

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    cls_t              op_cls;

    logic       pc_wr, pc_src, ir_wr, reg_src, reg_en, alu_src;
    logic       dmem_rd, dmem_wr, wr_src, retire, take;
    logic [3:0] alu_op;

    assign op_cls = classify(op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        retire    = 1'b0;
        take      = 1'b0;
        pc_wr     = 1'b0;
        pc_src    = 1'b0;
        ir_wr     = 1'b0;
        reg_src   = 1'b0;
        reg_en    = 1'b0;
        alu_src   = 1'b0;
        alu_op    = 4'b0000;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        wr_src    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = inst_op;
                case (classify(inst_op))
                    C_RTYPE, C_ITYPE, C_LW, C_SW: state_d = S_EXEC;
                    C_BR:                         state_d = S_BRANCH;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (op_cls == C_LW || op_cls == C_SW) begin
                    alu_src = 1'b1;
                    state_d = S_MEM;
                end else begin
                    alu_op  = alu_code(op_q[4:0]);
                    alu_src = (op_cls == C_ITYPE);
                    reg_src = (op_cls == C_RTYPE);
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Request held stable every wait cycle until the memory completes.
                if (op_cls == C_LW) dmem_rd = 1'b1;
                else                dmem_wr = 1'b1;
                if (dmem_ready) begin
                    if (op_cls == C_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_en  = 1'b1;
                wr_src  = (op_cls != C_LW);
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                // op bit 0 distinguishes bne from beq; zero is used in this same cycle.
                alu_op  = 4'b0001;
                take    = op_q[0] ? !zero : zero;
                pc_wr   = take;
                pc_src  = take;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (retire) retired_d = retired_q + CNT_W'(1);
    end

    // The FETCH handshake is combinational on imem_ready, so outputs are
    // qualified with rst_n to stay quiet while reset is held.
    assign PCWr    = rst_n & pc_wr;
    assign PCSrc   = rst_n & pc_src;
    assign IRWr    = rst_n & ir_wr;
    assign RegSrc  = rst_n & reg_src;
    assign RegEn   = rst_n & reg_en;
    assign ALUSrc  = rst_n & alu_src;
    assign ALUOp   = rst_n ? ALUOP_W'(alu_op) : '0;
    assign DmemRd  = rst_n & dmem_rd;
    assign DmemWr  = rst_n & dmem_wr;
    assign WrSrc   = rst_n & wr_src;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_SRA  = 5'b01001;
    localparam logic [4:0] OP_SL   = 5'b01010;
    localparam logic [4:0] OP_XORI = 5'b10110;
    localparam logic [4:0] OP_LW   = 5'b11100;
    localparam logic [4:0] OP_SW   = 5'b11101;
    localparam logic [4:0] OP_BEQ  = 5'b11110;
    localparam logic [4:0] OP_BNE  = 5'b11111;

    logic        clk;
    logic        rst_n;
    logic [4:0]  inst_op;
    logic        zero, imem_ready, dmem_ready;

    logic        PCWr, PCSrc, IRWr, RegSrc, RegEn, ALUSrc, DmemRd, DmemWr, WrSrc, illegal;
    logic [3:0]  ALUOp;
    logic [31:0] retired;

    logic        PCWr4, PCSrc4, IRWr4, RegSrc4, RegEn4, ALUSrc4, DmemRd4, DmemWr4, WrSrc4, illegal4;
    logic [3:0]  ALUOp4;
    logic [3:0]  retired4;

    logic [13:0] ctl;
    assign ctl = {PCWr, PCSrc, IRWr, RegSrc, RegEn, ALUSrc, ALUOp, DmemRd, DmemWr, WrSrc, illegal};

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.OP_W(5), .ALUOP_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .inst_op(inst_op), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .RegSrc(RegSrc), .RegEn(RegEn),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .DmemRd(DmemRd), .DmemWr(DmemWr),
        .WrSrc(WrSrc), .illegal(illegal), .retired(retired)
    );

    multicycle_controller #(.OP_W(5), .ALUOP_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .inst_op(inst_op), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .PCWr(PCWr4), .PCSrc(PCSrc4), .IRWr(IRWr4), .RegSrc(RegSrc4), .RegEn(RegEn4),
        .ALUSrc(ALUSrc4), .ALUOp(ALUOp4), .DmemRd(DmemRd4), .DmemWr(DmemWr4),
        .WrSrc(WrSrc4), .illegal(illegal4), .retired(retired4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Field order: PCWr PCSrc IRWr RegSrc RegEn ALUSrc ALUOp DmemRd DmemWr WrSrc illegal
    function automatic logic [13:0] ex(input logic pw, input logic ps, input logic ir,
                                       input logic rs, input logic re, input logic as,
                                       input logic [3:0] ao, input logic rd, input logic wr,
                                       input logic ws, input logic il);
        return {pw, ps, ir, rs, re, as, ao, rd, wr, ws, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; callers then drive inputs and wait #1 before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; inst_op = 5'b0; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
        #2;
        chk("reset_ctl",     32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,0,0,0,0)));
        chk("reset_retired", retired, 32'd0);

        // add, zero wait states
        tick(); rst_n = 1'b1; inst_op = OP_ADD; #1;
        chk("add_fetch",  32'(ctl), 32'(ex(1,0,1,0,0,0,4'b0000,0,0,0,0)));
        tick(); #1;
        chk("add_decode", 32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,0,0,0,0)));
        tick(); #1;
        chk("add_exec",   32'(ctl), 32'(ex(0,0,0,1,0,0,4'b0000,0,0,0,0)));
        tick(); #1;
        chk("add_wb",     32'(ctl), 32'(ex(0,0,0,0,1,0,4'b0000,0,0,1,0)));
        chk("add_wb_ret", retired, 32'd0);

        // lw with three data wait cycles
        tick(); inst_op = OP_LW; #1;
        chk("add_retired", retired, 32'd1);
        chk("lw_fetch",  32'(ctl), 32'(ex(1,0,1,0,0,0,4'b0000,0,0,0,0)));
        tick(); #1;
        chk("lw_decode", 32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,0,0,0,0)));
        tick(); #1;
        chk("lw_exec",   32'(ctl), 32'(ex(0,0,0,0,0,1,4'b0000,0,0,0,0)));
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_ready = (i == 3); #1;
            chk("lw_mem", 32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,1,0,0,0)));
        end
        tick(); dmem_ready = 1'b0; #1;
        chk("lw_wb",     32'(ctl), 32'(ex(0,0,0,0,1,0,4'b0000,0,0,0,0)));

        // sw with one instruction-memory wait cycle
        tick(); inst_op = OP_SW; imem_ready = 1'b0; #1;
        chk("lw_retired", retired, 32'd2);
        chk("sw_fetch_wait", 32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,0,0,0,0)));
        tick(); imem_ready = 1'b1; #1;
        chk("sw_fetch",  32'(ctl), 32'(ex(1,0,1,0,0,0,4'b0000,0,0,0,0)));
        tick(); #1;
        tick(); #1;
        chk("sw_exec",   32'(ctl), 32'(ex(0,0,0,0,0,1,4'b0000,0,0,0,0)));
        tick(); dmem_ready = 1'b1; #1;
        chk("sw_mem",    32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,0,1,0,0)));

        // beq taken, zero=1
        tick(); dmem_ready = 1'b0; inst_op = OP_BEQ; zero = 1'b1; #1;
        chk("sw_retired", retired, 32'd3);
        tick(); #1;
        tick(); #1;
        chk("beq_branch", 32'(ctl), 32'(ex(1,1,0,0,0,0,4'b0001,0,0,0,0)));

        // bne with zero=1 not taken, then zero drops in the same cycle
        tick(); inst_op = OP_BNE; #1;
        chk("beq_retired", retired, 32'd4);
        tick(); #1;
        tick(); #1;
        chk("bne_not_taken", 32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0001,0,0,0,0)));
        zero = 1'b0; #1;
        chk("bne_taken",     32'(ctl), 32'(ex(1,1,0,0,0,0,4'b0001,0,0,0,0)));

        // xori (I-type)
        tick(); inst_op = OP_XORI; #1;
        chk("bne_retired", retired, 32'd5);
        tick(); #1;
        tick(); #1;
        chk("xori_exec", 32'(ctl), 32'(ex(0,0,0,0,0,1,4'b0111,0,0,0,0)));
        tick(); #1;
        chk("xori_wb",   32'(ctl), 32'(ex(0,0,0,0,1,0,4'b0000,0,0,1,0)));

        // sl and sra (shift ALU codes are not the opcode low bits)
        tick(); inst_op = OP_SL; #1;
        tick(); #1;
        tick(); #1;
        chk("sl_exec",  32'(ctl), 32'(ex(0,0,0,1,0,0,4'b1001,0,0,0,0)));
        tick(); #1;
        tick(); inst_op = OP_SRA; #1;
        chk("sl_retired", retired, 32'd7);
        tick(); #1;
        tick(); #1;
        chk("sra_exec", 32'(ctl), 32'(ex(0,0,0,1,0,0,4'b1010,0,0,0,0)));
        tick(); #1;

        // sub, reset asserted mid-EXEC
        tick(); inst_op = OP_SUB; #1;
        chk("sra_retired", retired, 32'd8);
        tick(); #1;
        tick(); #1;
        chk("sub_exec", 32'(ctl), 32'(ex(0,0,0,1,0,0,4'b0001,0,0,0,0)));
        rst_n = 1'b0; #1;
        chk("midreset_ctl",      32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,0,0,0,0)));
        chk("midreset_retired",  retired, 32'd0);
        chk("midreset_retired4", 32'(retired4), 32'd0);
        tick(); rst_n = 1'b1; #1;
        chk("post_reset_fetch", 32'(ctl), 32'(ex(1,0,1,0,0,0,4'b0000,0,0,0,0)));

        // 17 not-taken beq: 32-bit count reaches 17, 4-bit count wraps to 1
        for (int i = 0; i < 17; i++) begin
            inst_op = OP_BEQ;
            tick(); #1;
            tick(); #1;
            tick(); #1;
            if (i == 15) chk("wrap16_retired4", 32'(retired4), 32'd0);
        end
        chk("run17_retired",  retired, 32'd17);
        chk("run17_retired4", 32'(retired4), 32'd1);

        // illegal opcode 00000 -> TRAP, terminal
        inst_op = 5'b00000; dmem_ready = 1'b1; #1;
        tick(); #1;
        chk("ill_decode", 32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,0,0,0,0)));
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("trap_ctl",     32'(ctl), 32'(ex(0,0,0,0,0,0,4'b0000,0,0,0,1)));
            chk("trap_retired", retired, 32'd17);
        end
        rst_n = 1'b0; #1;
        chk("trap_reset_illegal", 32'(illegal), 32'd0);
        chk("trap_reset_retired", retired, 32'd0);
        tick(); rst_n = 1'b1; #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
